qpsk_framer: RTL and testbench
==============================

Name: qpsk_framer

Overview:
Upstream feeder of the QPSK symbol mapper. Accepts payload bytes over a valid/ready stream and emits one dibit per symbol, MSB first. Each frame is preamble, sync word, length byte, then payload. Output follows the mapper's valid/ready symbol handshake and stalls without inserting filler symbols.

Parameters:
PREAMBLE_SYMS, 16, number of preamble symbols per frame (>=1); pattern alternates {I,Q}=00,11,00,11...
SYNC_WORD, 32'h1ACFFC1D, sync word sent MSB first after the preamble
SYNC_BITS, 32, width of SYNC_WORD; even, 2..64

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_start  in  1  frame request; sampled only in IDLE
i_len  in  8  payload byte count, captured with i_start; 0 is legal
i_data  in  8  payload byte
i_data_valid  in  1  payload byte valid
o_data_ready  out  1  byte accepted when i_data_valid && o_data_ready
o_I  out  1  symbol I bit (first bit of dibit)
o_Q  out  1  symbol Q bit (second bit of dibit)
o_valid  out  1  symbol valid
i_mod_ready  in  1  downstream ready; symbol transferred when o_valid && i_mod_ready
o_busy  out  1  high whenever state != IDLE
o_done  out  1  one-cycle pulse on the cycle after the frame's last symbol transfer

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; o_valid=0, o_I=0, o_Q=0, o_busy=0, o_done=0, o_data_ready=0; all counters and shift registers cleared. Reset mid-frame abandons the frame; no further symbols are emitted.
- States and transitions:
  - IDLE -> PREAMBLE on i_start.
  - PREAMBLE -> SYNC after PREAMBLE_SYMS transfers.
  - SYNC -> LEN after SYNC_BITS/2 transfers.
  - LEN -> PAYLOAD after 4 transfers when len>0.
  - LEN -> IDLE after 4 transfers when len=0.
  - PAYLOAD -> IDLE after the 4th dibit of the last byte transfers.
- Start: i_start in IDLE at edge N gives o_valid=1 with {I,Q}=00 after edge N. i_start is ignored outside IDLE. i_len is latched only on accepted starts.
- Symbol hold: o_valid, o_I and o_Q stay constant until transferred. A transfer advances to the next symbol on the same edge. With i_mod_ready held high, there is one symbol per cycle with no bubbles inside preamble, sync and len, or across the boundaries between them.
- Dibit order for every byte/word is MSB first: b[7:6], b[5:4], b[3:2], b[1:0]. The first bit of each pair drives o_I and the second drives o_Q.
- Payload input:
  - o_data_ready = (state==PAYLOAD) && bytes_left>0 && (symbol register empty || (transfer this cycle && current dibit is the byte's 4th)).
  - This is combinational from i_mod_ready and allows back-to-back bytes at 4 cycles/byte.
  - In LEN with len>0, a byte may be preloaded on the cycle the 4th len dibit transfers, so there is no bubble into PAYLOAD.
- Underflow: if no byte is available when one is needed, o_valid=0 until i_data_valid. The frame continues afterwards, with no filler and no abort.
- Bytes offered outside PAYLOAD, or beyond len, are not accepted (o_data_ready=0).
- Simultaneous events:
  - Final transfer and i_start on the same cycle: the start is ignored, because the state is not yet IDLE.
  - o_done asserts on the cycle after the final transfer, with o_busy=0 on that cycle.
  - i_start is accepted on or after the o_done cycle.
- Frame length in symbols = PREAMBLE_SYMS + SYNC_BITS/2 + 4 + 4*len.
- o_done is registered. Counters are sized to the parameters: PREAMBLE_SYMS, SYNC_BITS/2, and 8-bit bytes_left plus 2-bit dibit index.

Test Plan:
- Reset then i_start with i_len=0, i_mod_ready=1 -> o_valid high from the next cycle for exactly 36 consecutive cycles.
  - Symbols 0..15: alternating 00,11.
  - Symbols 16..19: 00,01,10,10 (0x1A).
  - Last 4 symbols: 00,00,00,00.
  - o_done pulses once; o_data_ready never asserts.
- i_len=2, bytes 0xE4 and 0x1B presented continuously, i_mod_ready=1 -> 44 contiguous symbols; len dibits 00,00,00,10; payload dibits 11,10,01,00,00,01,10,11; each byte accepted exactly once.
- Same frame with i_mod_ready toggling 1,0,1,0 -> o_I, o_Q and o_valid stay stable on every ready=0 cycle, and the symbol sequence is identical to the previous case.
- i_len=1 with i_data_valid withheld 5 cycles after PAYLOAD entry -> o_valid=0 for those cycles; the frame resumes when the byte is accepted; total transfers = 40.
- rst pulsed at symbol 20 of an i_len=3 frame -> o_valid=0 next cycle, o_busy=0, no o_done. A new i_start then restarts from preamble symbol 00.
- i_start pulsed mid-frame and on the final-transfer cycle -> both ignored; only one frame is emitted and o_done pulses once.

Source files
------------

// File: rtl/qpsk_framer.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_framer
// Function : Frames payload bytes as preamble/sync/len/payload dibits for the QPSK mapper.
// Revision : 1.0
// ============================================================================
module qpsk_framer #(
    parameter int                 PREAMBLE_SYMS = 16,
    parameter int                 SYNC_BITS     = 32,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD   = 32'h1ACFFC1D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_len,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_data_ready,
    output logic       o_I,
    output logic       o_Q,
    output logic       o_valid,
    input  logic       i_mod_ready,
    output logic       o_busy,
    output logic       o_done
);

    localparam int SYNC_SYMS = SYNC_BITS / 2;
    localparam int CNT_MAX   = (PREAMBLE_SYMS > SYNC_SYMS) ? PREAMBLE_SYMS : SYNC_SYMS;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_SYMS - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_SYMS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRE     = 3'd1;
    localparam logic [2:0] S_SYNC    = 3'd2;
    localparam logic [2:0] S_LEN     = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [CNT_W-1:0]     cnt;
    logic [SYNC_BITS-1:0] sync_sr;
    logic [7:0]           byte_sr;
    logic [7:0]           bytes_left;
    logic [1:0]           dib;
    logic                 have_byte;
    logic                 done_q;
    logic                 xfer;
    logic                 accept;
    logic                 last_sym;

    assign xfer     = o_valid & i_mod_ready;
    assign accept   = i_data_valid & o_data_ready;
    assign last_sym = xfer && (dib == 2'd3) && (bytes_left == 8'd0)
                      && ((state == S_LEN) || (state == S_PAYLOAD));
    assign o_busy   = (state != S_IDLE);
    assign o_done   = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (i_start) state_next = S_PRE;
            S_PRE:     if (xfer && (cnt == PRE_LAST)) state_next = S_SYNC;
            S_SYNC:    if (xfer && (cnt == SYNC_LAST)) state_next = S_LEN;
            S_LEN:     if (xfer && (dib == 2'd3))
                           state_next = (bytes_left == 8'd0) ? S_IDLE : S_PAYLOAD;
            S_PAYLOAD: if (last_sym) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // The symbol shown is derived from the current state's counter or shift register,
    // so it holds naturally until the mapper takes it.
    always_comb begin
        o_valid      = 1'b0;
        o_I          = 1'b0;
        o_Q          = 1'b0;
        o_data_ready = 1'b0;
        case (state)
            S_PRE: begin
                o_valid = 1'b1;
                o_I     = cnt[0];
                o_Q     = cnt[0];
            end
            S_SYNC: begin
                o_valid    = 1'b1;
                {o_I, o_Q} = sync_sr[SYNC_BITS-1 -: 2];
            end
            S_LEN: begin
                o_valid      = 1'b1;
                {o_I, o_Q}   = byte_sr[7:6];
                o_data_ready = (bytes_left != 8'd0) && i_mod_ready && (dib == 2'd3);
            end
            S_PAYLOAD: begin
                o_valid      = have_byte;
                {o_I, o_Q}   = byte_sr[7:6];
                o_data_ready = (bytes_left != 8'd0)
                               && (!have_byte || (i_mod_ready && (dib == 2'd3)));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sync_sr    <= '0;
            byte_sr    <= 8'd0;
            bytes_left <= 8'd0;
            dib        <= 2'd0;
            have_byte  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_sym;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        cnt        <= '0;
                        sync_sr    <= SYNC_WORD;
                        byte_sr    <= i_len;
                        bytes_left <= i_len;
                        dib        <= 2'd0;
                        have_byte  <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (xfer) cnt <= (cnt == PRE_LAST) ? '0 : cnt + 1'b1;
                end
                S_SYNC: begin
                    if (xfer) begin
                        sync_sr <= sync_sr << 2;
                        cnt     <= (cnt == SYNC_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                S_LEN, S_PAYLOAD: begin
                    if (xfer) begin
                        byte_sr <= byte_sr << 2;
                        dib     <= dib + 2'd1;
                        if (dib == 2'd3) have_byte <= 1'b0;
                    end
                    // A newly accepted byte overrides the shift; dib has wrapped to 0 by now.
                    if (accept) begin
                        byte_sr    <= i_data;
                        have_byte  <= 1'b1;
                        bytes_left <= bytes_left - 8'd1;
                        dib        <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qpsk_framer.sv
`default_nettype none
// Testbench for qpsk_framer: randomized frames checked against a symbol-list reference model.
module tb_qpsk_framer;

    localparam int          PRE = 16;
    localparam int          SB  = 32;
    localparam logic [31:0] SW  = 32'h1ACFFC1D;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [7:0] i_len;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       o_data_ready;
    logic       o_I;
    logic       o_Q;
    logic       o_valid;
    logic       i_mod_ready;
    logic       o_busy;
    logic       o_done;

    always #5 clk = ~clk;

    qpsk_framer #(
        .PREAMBLE_SYMS(PRE),
        .SYNC_BITS    (SB),
        .SYNC_WORD    (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_data      (i_data),
        .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready),
        .o_I         (o_I),
        .o_Q         (o_Q),
        .o_valid     (o_valid),
        .i_mod_ready (i_mod_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    int         tests = 0;
    int         fails = 0;
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] acc_q[$];
    int         done_cnt, done_busy_bad, bubbles, stall_viol, done_k, post_act;
    bit         timeout;

    // Reference: the frame is just a list of dibits, each field read MSB first.
    function automatic void build_expected(input int len);
        exp_q.delete();
        for (int i = 0; i < PRE; i++) exp_q.push_back((i % 2 == 1) ? 2'b11 : 2'b00);
        for (int i = 0; i < SB / 2; i++) exp_q.push_back(2'((SW >> (SB - 2 - 2 * i)) & 32'h3));
        for (int i = 0; i < 4; i++) exp_q.push_back(2'((len >> (6 - 2 * i)) & 3));
        for (int b = 0; b < len; b++)
            for (int i = 0; i < 4; i++) exp_q.push_back(2'((tx_bytes[b] >> (6 - 2 * i)) & 8'h3));
    endfunction

    function automatic int seq_diff();
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic bit acc_ok();
        if (acc_q.size() != tx_bytes.size()) return 1'b0;
        for (int i = 0; i < acc_q.size(); i++) if (acc_q[i] !== tx_bytes[i]) return 1'b0;
        return 1'b1;
    endfunction

    // rdy_pct < 0 toggles ready 1,0,1,0; data valid is withheld before cycle val_from.
    task automatic run_frame(input int len, input int rdy_pct, input int val_pct,
                             input int val_from, input bit start_noise);
        int bi = 0;
        int post = 0;
        int total;
        bit seen_done = 1'b0;
        bit prev_v = 1'b0, prev_r = 1'b0, prev_i = 1'b0, prev_q = 1'b0;
        obs_q.delete();
        acc_q.delete();
        done_cnt = 0; done_busy_bad = 0; bubbles = 0; stall_viol = 0; done_k = -1; post_act = 0;
        build_expected(len);
        total = exp_q.size();
        @(posedge clk); #1;
        i_start = 1'b1; i_len = 8'(len); i_data_valid = 1'b0; i_mod_ready = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            i_mod_ready  = (rdy_pct < 0) ? (k % 2 == 0) : ($urandom_range(99) < rdy_pct);
            i_data_valid = (k >= val_from) && ($urandom_range(99) < val_pct);
            i_data       = (bi < len) ? tx_bytes[bi] : 8'($urandom);
            i_start      = start_noise && (obs_q.size() < total);
            i_len        = 8'($urandom);
            #1;
            if (prev_v && !prev_r && ({o_valid, o_I, o_Q} !== {1'b1, prev_i, prev_q})) stall_viol++;
            if (o_done) begin
                done_cnt++;
                if (o_busy) done_busy_bad++;
                if (!seen_done) done_k = k;
                seen_done = 1'b1;
            end
            if (seen_done && !o_done && (o_valid || o_busy)) post_act++;
            if (o_busy && !o_valid) bubbles++;
            if (o_valid && i_mod_ready) obs_q.push_back({o_I, o_Q});
            if (i_data_valid && o_data_ready) begin
                acc_q.push_back(i_data);
                bi++;
            end
            prev_v = o_valid; prev_r = i_mod_ready; prev_i = o_I; prev_q = o_Q;
            @(posedge clk); #1;
            if (seen_done) post++;
            if (post > 3) break;
        end
        timeout = !seen_done;
        i_start = 1'b0; i_data_valid = 1'b0; i_mod_ready = 1'b0;
    endtask

    task automatic fill_bytes(input int n);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_len = 8'h05; i_data = 8'hA5;
        i_data_valid = 1'b1; i_mod_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({o_valid, o_I, o_Q, o_busy, o_done, o_data_ready} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {o_valid, o_I, o_Q, o_busy, o_done, o_data_ready});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({o_valid, o_busy, o_data_ready} !== 3'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got %b want 000", {o_valid, o_busy, o_data_ready});
        end
        i_data_valid = 1'b0;
    endtask

    task automatic test_len0();
        int d;
        fill_bytes(0);
        run_frame(0, 100, 100, 0, 1'b0);
        d = seq_diff();
        tests++;
        if (timeout || d >= 0) begin
            fails++;
            $display("FAIL len0_seq: timeout=%0d first_diff=%0d got_syms=%0d want_syms=%0d",
                     timeout, d, obs_q.size(), exp_q.size());
        end
        tests++;
        if (obs_q.size() < 20 || {obs_q[16], obs_q[17], obs_q[18], obs_q[19]} !== 8'b00_01_10_10) begin
            fails++;
            $display("FAIL len0_sync_head: got size %0d, want 00,01,10,10", obs_q.size());
        end
        tests++;
        if (obs_q.size() != 36 || {obs_q[32], obs_q[33], obs_q[34], obs_q[35]} !== 8'h00) begin
            fails++;
            $display("FAIL len0_len_dibits: got size %0d want 36 with last four 00", obs_q.size());
        end
        tests++;
        if (done_cnt != 1 || done_k != 36 || bubbles != 0) begin
            fails++;
            $display("FAIL len0_timing: done_cnt=%0d done_k=%0d bubbles=%0d want 1,36,0",
                     done_cnt, done_k, bubbles);
        end
        tests++;
        if (acc_q.size() != 0 || done_busy_bad != 0 || post_act != 0) begin
            fails++;
            $display("FAIL len0_misc: accepted=%0d done_busy=%0d post=%0d want 0,0,0",
                     acc_q.size(), done_busy_bad, post_act);
        end
    endtask

    task automatic test_len2();
        logic [1:0] pay[8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        int d;
        int bad = 0;
        tx_bytes.delete();
        tx_bytes.push_back(8'hE4);
        tx_bytes.push_back(8'h1B);
        run_frame(2, 100, 100, 0, 1'b0);
        d = seq_diff();
        tests++;
        if (timeout || d >= 0 || done_k != 44 || bubbles != 0) begin
            fails++;
            $display("FAIL len2_seq: timeout=%0d first_diff=%0d done_k=%0d bubbles=%0d want -1,44,0",
                     timeout, d, done_k, bubbles);
        end
        for (int i = 0; i < 8; i++) if (obs_q.size() != 44 || obs_q[36 + i] !== pay[i]) bad++;
        if (obs_q.size() == 44 && {obs_q[32], obs_q[33], obs_q[34], obs_q[35]} !== 8'b00_00_00_10) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL len2_dibits: %0d wrong len/payload dibits, want 0", bad);
        end
        tests++;
        if (!acc_ok()) begin
            fails++;
            $display("FAIL len2_accept: accepted %0d bytes, want E4,1B once each", acc_q.size());
        end
    endtask

    task automatic test_stall();
        int d;
        tx_bytes.delete();
        tx_bytes.push_back(8'hE4);
        tx_bytes.push_back(8'h1B);
        run_frame(2, -1, 100, 0, 1'b0);
        d = seq_diff();
        tests++;
        if (timeout || d >= 0) begin
            fails++;
            $display("FAIL stall_seq: timeout=%0d first_diff=%0d want -1", timeout, d);
        end
        tests++;
        if (stall_viol != 0 || !acc_ok() || done_cnt != 1) begin
            fails++;
            $display("FAIL stall_hold: violations=%0d accepted=%0d done=%0d want 0,2,1",
                     stall_viol, acc_q.size(), done_cnt);
        end
    endtask

    task automatic test_underflow();
        int d;
        fill_bytes(1);
        // Byte first offered at cycle 40; it is wanted from cycle 35 (last len dibit).
        run_frame(1, 100, 100, 40, 1'b0);
        d = seq_diff();
        tests++;
        if (timeout || d >= 0 || obs_q.size() != 40) begin
            fails++;
            $display("FAIL underflow_seq: timeout=%0d first_diff=%0d syms=%0d want -1,40",
                     timeout, d, obs_q.size());
        end
        tests++;
        if (bubbles != 5 || !acc_ok() || done_cnt != 1) begin
            fails++;
            $display("FAIL underflow_gap: bubbles=%0d accepted=%0d done=%0d want 5,1,1",
                     bubbles, acc_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int nval = 0;
        int act = 0;
        int d;
        fill_bytes(3);
        build_expected(3);
        @(posedge clk); #1;
        i_start = 1'b1; i_len = 8'd3; i_mod_ready = 1'b1; i_data_valid = 1'b1; i_data = tx_bytes[0];
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_valid) nval++;
            @(posedge clk); #1;
        end
        tests++;
        if (nval != 20 || {o_valid, o_I, o_Q} !== {1'b1, exp_q[20]}) begin
            fails++;
            $display("FAIL midrst_prefix: valid=%0d sym20=%b want 20,1%b", nval, {o_valid, o_I, o_Q}, exp_q[20]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({o_valid, o_busy, o_done} !== 3'b000) begin
            fails++;
            $display("FAIL midrst_state: got %b want 000", {o_valid, o_busy, o_done});
        end
        for (int k = 0; k < 10; k++) begin
            if (o_valid || o_busy || o_done || o_data_ready) act++;
            @(posedge clk); #1;
        end
        i_data_valid = 1'b0;
        tests++;
        if (act != 0) begin
            fails++;
            $display("FAIL midrst_quiet: %0d active cycles after reset want 0", act);
        end
        fill_bytes(0);
        run_frame(0, 100, 100, 0, 1'b0);
        d = seq_diff();
        tests++;
        if (timeout || d >= 0 || done_cnt != 1) begin
            fails++;
            $display("FAIL midrst_restart: timeout=%0d first_diff=%0d done=%0d want -1,1", timeout, d, done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int d;
        fill_bytes(3);
        run_frame(3, 100, 100, 0, 1'b1);
        d = seq_diff();
        tests++;
        if (timeout || d >= 0) begin
            fails++;
            $display("FAIL start_ign_seq: timeout=%0d first_diff=%0d want -1", timeout, d);
        end
        tests++;
        if (done_cnt != 1 || post_act != 0 || !acc_ok()) begin
            fails++;
            $display("FAIL start_ign_once: done=%0d post=%0d accepted=%0d want 1,0,3",
                     done_cnt, post_act, acc_q.size());
        end
    endtask

    task automatic test_random();
        int d;
        int len;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(0, 5);
            fill_bytes(len);
            run_frame(len, $urandom_range(40, 90), $urandom_range(30, 90), 0, 1'($urandom_range(1)));
            d = seq_diff();
            tests++;
            if (timeout || d >= 0 || stall_viol != 0 || !acc_ok()
                || done_cnt != 1 || done_busy_bad != 0 || post_act != 0) begin
                fails++;
                $display("FAIL random_frame%0d: len=%0d timeout=%0d diff=%0d stall=%0d acc=%0d done=%0d dbusy=%0d post=%0d",
                         f, len, timeout, d, stall_viol, acc_q.size(), done_cnt, done_busy_bad, post_act);
            end
        end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_len = 8'd0; i_data = 8'd0;
        i_data_valid = 1'b0; i_mod_ready = 1'b0;
        test_reset();
        test_len0();
        test_len2();
        test_stall();
        test_underflow();
        test_reset_midframe();
        test_start_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
